// File: rtl/pad_input_regs.sv
// pad_input_regs: CPU-facing register block for the SPI gamepad receiver.
// Debounces the receiver's button word and exposes the result, sticky
// press/release events and a maskable press interrupt as four 16-bit
// registers on a single-cycle peripheral bus.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   pad_btn        raw active-high button word (same clock domain)
//   bus_addr       register select: 0 CURRENT, 1 PRESSED, 2 RELEASED, 3 IRQ_MASK
//   bus_write_en   write strobe, one cycle per access
//   bus_read_en    read strobe, one cycle per access
//   bus_write_data write data
//   bus_read_data  registered read data, held until the next read
//   bus_read_ready one-cycle pulse marking bus_read_data valid
//   irq            level interrupt, |(pressed & irq_mask), registered
module pad_input_regs #(
  parameter int unsigned PAD_BUTTONS     = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PAD_BUTTONS-1:0] pad_btn,
  input  logic [1:0]             bus_addr,
  input  logic                   bus_write_en,
  input  logic                   bus_read_en,
  input  logic [15:0]            bus_write_data,
  output logic [15:0]            bus_read_data,
  output logic                   bus_read_ready,
  output logic                   irq
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 0) ? (DEBOUNCE_CYCLES - 1) : 0);

  localparam logic [1:0] ADDR_CURRENT  = 2'd0;
  localparam logic [1:0] ADDR_PRESSED  = 2'd1;
  localparam logic [1:0] ADDR_RELEASED = 2'd2;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd3;

  logic [PAD_BUTTONS-1:0] pad_q;
  logic [PAD_BUTTONS-1:0] stable;
  logic [PAD_BUTTONS-1:0] pressed;
  logic [PAD_BUTTONS-1:0] released;
  logic [PAD_BUTTONS-1:0] irq_mask;
  logic [CNT_W-1:0]       count;

  logic [PAD_BUTTONS-1:0] stable_next;
  logic [CNT_W-1:0]       count_next;
  logic [PAD_BUTTONS-1:0] pressed_next;
  logic [PAD_BUTTONS-1:0] released_next;
  logic [PAD_BUTTONS-1:0] irq_mask_next;
  logic [PAD_BUTTONS-1:0] clr_pressed;
  logic [PAD_BUTTONS-1:0] clr_released;
  logic [PAD_BUTTONS-1:0] wdata_btn;
  logic [DATA_W-1:0]      read_mux;
  logic                   pad_changing;

  // Upper write-data bits beyond the button count carry no meaning.
  logic unused_wdata;
  assign unused_wdata = ^bus_write_data;

  assign wdata_btn = bus_write_data[PAD_BUTTONS-1:0];

  // pad_q is about to take a different value this edge: the window restarts.
  assign pad_changing = (pad_btn != pad_q);

  // Debounce: accept pad_q once it has held, unchanged and different from
  // stable, for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    stable_next = stable;
    count_next  = count;
    if (DEBOUNCE_CYCLES == 0) begin
      stable_next = pad_q;
      count_next  = '0;
    end else if ((pad_q == stable) || pad_changing) begin
      count_next = '0;
    end else if (count == CNT_LAST) begin
      stable_next = pad_q;
      count_next  = '0;
    end else begin
      count_next = count + CNT_W'(1);
    end
  end

  // Sticky events and W1C; an event in the same cycle as its clear wins.
  always_comb begin
    clr_pressed   = '0;
    clr_released  = '0;
    irq_mask_next = irq_mask;
    if (bus_write_en) begin
      case (bus_addr)
        ADDR_PRESSED:  clr_pressed   = wdata_btn;
        ADDR_RELEASED: clr_released  = wdata_btn;
        ADDR_IRQ_MASK: irq_mask_next = wdata_btn;
        default:       ;
      endcase
    end
    pressed_next  = (pressed  & ~clr_pressed)  | (stable_next & ~stable);
    released_next = (released & ~clr_released) | (~stable_next & stable);
  end

  // Read mux over pre-update register contents.
  always_comb begin
    read_mux = '0;
    case (bus_addr)
      ADDR_CURRENT:  read_mux = DATA_W'(stable);
      ADDR_PRESSED:  read_mux = DATA_W'(pressed);
      ADDR_RELEASED: read_mux = DATA_W'(released);
      ADDR_IRQ_MASK: read_mux = DATA_W'(irq_mask);
      default:       read_mux = '0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_q          <= '0;
      stable         <= '0;
      count          <= '0;
      pressed        <= '0;
      released       <= '0;
      irq_mask       <= '0;
      bus_read_data  <= '0;
      bus_read_ready <= 1'b0;
      irq            <= 1'b0;
    end else begin
      pad_q          <= pad_btn;
      stable         <= stable_next;
      count          <= count_next;
      pressed        <= pressed_next;
      released       <= released_next;
      irq_mask       <= irq_mask_next;
      bus_read_ready <= bus_read_en;
      if (bus_read_en) begin
        bus_read_data <= read_mux;
      end
      irq            <= |(pressed & irq_mask);
    end
  end

endmodule

// File: tb/tb_pad_input_regs.sv
// tb_pad_input_regs: directed bench for pad_input_regs (12 buttons, 4-cycle
// debounce). A reference model tracks the register file from the button
// sample history and is compared against the bus outputs and irq on every
// cycle; directed reads additionally pin hand-computed register values.
module tb_pad_input_regs;

  localparam int unsigned PB = 12;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [PB-1:0] pad_btn;
  logic [1:0]    bus_addr;
  logic          bus_write_en;
  logic          bus_read_en;
  logic [15:0]   bus_write_data;
  logic [15:0]   bus_read_data;
  logic          bus_read_ready;
  logic          irq;

  int vectors     = 0;
  int miscompares = 0;

  pad_input_regs #(
    .PAD_BUTTONS    (PB),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pad_btn       (pad_btn),
    .bus_addr      (bus_addr),
    .bus_write_en  (bus_write_en),
    .bus_read_en   (bus_read_en),
    .bus_write_data(bus_write_data),
    .bus_read_data (bus_read_data),
    .bus_read_ready(bus_read_ready),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: stable takes the sampled button value once the last
  // D+1 samples agree and differ from the current stable value.
  logic [PB-1:0] hist[$];
  logic [PB-1:0] m_stable, m_pressed, m_released, m_mask, new_st, clr_p, clr_r;
  logic [15:0]   m_rdata;
  logic          m_rready, m_irq, all_eq;
  logic          checking = 1'b0;

  function automatic logic [15:0] reg_val(input logic [1:0] a);
    case (a)
      2'd0:    return 16'(m_stable);
      2'd1:    return 16'(m_pressed);
      2'd2:    return 16'(m_released);
      default: return 16'(m_mask);
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      hist.push_back('0);
      m_stable = '0; m_pressed = '0; m_released = '0; m_mask = '0;
      m_rdata = '0; m_rready = 1'b0; m_irq = 1'b0;
      checking = 1'b1;
    end else begin
      if (bus_read_en) begin
        m_rdata  = reg_val(bus_addr);
        m_rready = 1'b1;
      end else begin
        m_rready = 1'b0;
      end
      m_irq = |(m_pressed & m_mask);
      hist.push_back(pad_btn);
      if (hist.size() > int'(D + 1)) void'(hist.pop_front());
      new_st = m_stable;
      if (hist.size() == int'(D + 1)) begin
        all_eq = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 1'b0;
        if (all_eq && (hist[0] != m_stable)) new_st = hist[0];
      end
      clr_p = (bus_write_en && bus_addr == 2'd1) ? bus_write_data[PB-1:0] : '0;
      clr_r = (bus_write_en && bus_addr == 2'd2) ? bus_write_data[PB-1:0] : '0;
      m_pressed  = (m_pressed  & ~clr_p) | (new_st & ~m_stable);
      m_released = (m_released & ~clr_r) | (~new_st & m_stable);
      if (bus_write_en && bus_addr == 2'd3) m_mask = bus_write_data[PB-1:0];
      m_stable = new_st;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("model_ready", 16'(bus_read_ready), 16'(m_rready));
      check("model_irq",   16'(irq),            16'(m_irq));
      check("model_rdata", bus_read_data,       m_rdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [15:0] exp, input string name);
    bus_addr    = a;
    bus_read_en = 1'b1;
    tick(1);
    bus_read_en = 1'b0;
    check({name, "_ready"}, 16'(bus_read_ready), 16'h0001);
    check(name, bus_read_data, exp);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    bus_addr       = a;
    bus_write_data = d;
    bus_write_en   = 1'b1;
    tick(1);
    bus_write_en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pad_btn = '0; bus_addr = '0;
    bus_write_en = 1'b0; bus_read_en = 1'b0; bus_write_data = '0;
    tick(1);
    do_reset();
    tick(2);
    check("reset_irq", 16'(irq), 16'h0000);
    check("reset_ready", 16'(bus_read_ready), 16'h0000);
    bus_rd(2'd0, 16'h0000, "reset_current");
    bus_rd(2'd1, 16'h0000, "reset_pressed");
    bus_rd(2'd2, 16'h0000, "reset_released");
    bus_rd(2'd3, 16'h0000, "reset_mask");

    // 1: single press accepted exactly D edges after the first sample
    pad_btn = 12'h001;
    for (int i = 0; i < 4; i++) bus_rd(2'd0, 16'h0000, "t1_current_early");
    bus_rd(2'd1, 16'h0000, "t1_pressed_early");
    bus_rd(2'd0, 16'h0001, "t1_current");
    bus_rd(2'd1, 16'h0001, "t1_pressed");
    bus_rd(2'd2, 16'h0000, "t1_released");

    // 2: glitch shorter than the window is rejected
    do_reset();
    pad_btn = 12'h003;
    tick(3);
    pad_btn = 12'h000;
    tick(8);
    bus_rd(2'd0, 16'h0000, "t2_current");
    bus_rd(2'd1, 16'h0000, "t2_pressed");
    bus_rd(2'd2, 16'h0000, "t2_released");

    // 3: partial release, W1C, write to read-only CURRENT
    pad_btn = 12'h003;
    tick(8);
    bus_rd(2'd0, 16'h0003, "t3_current_3");
    pad_btn = 12'h001;
    tick(8);
    bus_rd(2'd0, 16'h0001, "t3_current_1");
    bus_rd(2'd2, 16'h0002, "t3_released");
    bus_wr(2'd2, 16'h0002);
    bus_rd(2'd2, 16'h0000, "t3_released_clr");
    bus_wr(2'd0, 16'hFFFF);
    bus_rd(2'd0, 16'h0001, "t3_current_ro");
    bus_rd(2'd1, 16'h0003, "t3_pressed_noclr");
    bus_rd(2'd1, 16'h0003, "t3_pressed_noclr2");

    // 4: masked interrupt and its clear
    bus_wr(2'd1, 16'h0FFF);
    pad_btn = 12'h000;
    tick(8);
    bus_wr(2'd3, 16'hF010);
    bus_rd(2'd3, 16'h0010, "t4_mask");
    bus_rd(2'd1, 16'h0000, "t4_pressed_clr");
    pad_btn = 12'h011;
    tick(8);
    check("t4_irq_set", 16'(irq), 16'h0001);
    bus_wr(2'd1, 16'h0010);
    check("t4_irq_lag", 16'(irq), 16'h0001);
    tick(1);
    check("t4_irq_clr", 16'(irq), 16'h0000);
    bus_rd(2'd1, 16'h0001, "t4_pressed");

    // 5: press event on bit 2 coincides with its W1C; set wins
    pad_btn = 12'h015;
    tick(4);
    bus_wr(2'd1, 16'h0004);
    bus_rd(2'd1, 16'h0005, "t5_pressed");

    // 6: read-ready pulse width and data hold
    bus_addr    = 2'd0;
    bus_read_en = 1'b1;
    tick(1);
    bus_read_en = 1'b0;
    check("t6_ready_hi", 16'(bus_read_ready), 16'h0001);
    check("t6_data",     bus_read_data,       16'h0015);
    tick(1);
    check("t6_ready_lo", 16'(bus_read_ready), 16'h0000);
    check("t6_data_hold", bus_read_data,      16'h0015);

    // simultaneous read and W1C of PRESSED returns pre-write value
    bus_addr = 2'd1; bus_write_data = 16'h0005;
    bus_read_en = 1'b1; bus_write_en = 1'b1;
    tick(1);
    bus_read_en = 1'b0; bus_write_en = 1'b0;
    check("t6_rw_data", bus_read_data, 16'h0005);
    bus_rd(2'd1, 16'h0000, "t6_rw_cleared");

    // reset mid-debounce discards the pending value
    pad_btn = 12'h0F0;
    tick(2);
    reset = 1'b1;
    pad_btn = 12'h000;
    tick(2);
    reset = 1'b0;
    tick(8);
    bus_rd(2'd0, 16'h0000, "t6_rst_current");
    bus_rd(2'd1, 16'h0000, "t6_rst_pressed");
    bus_rd(2'd2, 16'h0000, "t6_rst_released");
    check("t6_rst_irq", 16'(irq), 16'h0000);

    // button held across reset is reported as a fresh press
    pad_btn = 12'h0F0;
    do_reset();
    bus_rd(2'd0, 16'h0000, "t6_held_early");
    tick(8);
    bus_rd(2'd0, 16'h00F0, "t6_held_current");
    bus_rd(2'd1, 16'h00F0, "t6_held_pressed");
    bus_rd(2'd2, 16'h0000, "t6_held_released");

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
